axi4_reg_slice: RTL and testbench

- Parametrised AXI4 register slice between an upstream slave port (s_axi_*) and a downstream master port (m_axi_*).
- Breaks timing paths on all five channels (AW, W, B, AR, R).
- Address width, data width and ID width are generic.
- Each channel independently selects bypass, full-throughput skid-buffer or light single-register mode.
- Inserted between interconnect and DUT, or in front of any AXI4 master/slave pair.

---
 rtl/axi4_reg_slice.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_axi4_reg_slice.sv | 493 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_reg_slice.sv
// AXI4 register slice between an upstream slave port (s_axi_*) and a
// downstream master port (m_axi_*). Each of the five channels can be a bypass
// (MODE 0), a full-throughput 2-entry skid buffer (MODE 1) or a light
// single-register stage (MODE 2).
// Ports: aclk/aresetn; s_axi_{aw,w,ar}* in / s_axi_{b,r}* out (upstream);
//        m_axi_{aw,w,ar}* out / m_axi_{b,r}* in (downstream).

// One registered channel stage: source side (valid_i/ready_o/data_i),
// sink side (valid_o/ready_i/data_o). MODE 1 = skid buffer, MODE 2 = light.
module axi4_reg_slice_chan #(
  parameter int unsigned W    = 8,
  parameter int unsigned MODE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_FULL = 2'd2} state_e;

  state_e         state_q, state_d;
  logic           ready_q, ready_d;
  logic           valid_q, valid_d;
  logic [W-1:0]   main_q, main_d;
  logic           accept, drain;

  assign accept  = valid_i & ready_q;
  assign drain   = valid_q & ready_i;
  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign data_o  = main_q;

  if (MODE == 1) begin : g_full
    logic [W-1:0] skid_q, skid_d;

    // Next state; handshake flags are derived from the next state so they come out of flops.
    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
        ST_EMPTY: if (accept) begin
          state_d = ST_ONE;
          main_d  = data_i;
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_d = data_i;
          end else if (accept) begin
            state_d = ST_FULL;
            skid_d  = data_i;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: if (drain) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
        default: state_d = ST_EMPTY;
      endcase
      ready_d = (state_d != ST_FULL);
      valid_d = (state_d != ST_EMPTY);
    end

    // Skid payload is not reset; valid_q qualifies it.
    always_ff @(posedge clk) begin
      skid_q <= skid_d;
    end
  end else begin : g_light
    // Single entry: never accepts while holding a beat.
    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      case (state_q)
        ST_EMPTY: if (accept) begin
          state_d = ST_ONE;
          main_d  = data_i;
        end
        ST_ONE: if (drain) state_d = ST_EMPTY;
        default: state_d = ST_EMPTY;
      endcase
      ready_d = (state_d == ST_EMPTY);
      valid_d = (state_d == ST_ONE);
    end
  end

  // Control flops; ready stays low through reset and rises on the first edge after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  // Main payload is not reset; valid_q qualifies it.
  always_ff @(posedge clk) begin
    main_q <= main_d;
  end
endmodule

module axi4_reg_slice #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ID_W    = 4,
  parameter int unsigned MODE_AW = 1,
  parameter int unsigned MODE_W  = 1,
  parameter int unsigned MODE_B  = 1,
  parameter int unsigned MODE_AR = 1,
  parameter int unsigned MODE_R  = 1
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ID_W-1:0]   s_axi_awid,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [7:0]        s_axi_awlen,
  input  logic [2:0]        s_axi_awsize,
  input  logic [1:0]        s_axi_awburst,
  input  logic              s_axi_awlock,
  input  logic [3:0]        s_axi_awcache,
  input  logic [2:0]        s_axi_awprot,
  input  logic [3:0]        s_axi_awregion,
  input  logic [3:0]        s_axi_awqos,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [DATA_W-1:0] s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic              s_axi_wlast,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [ID_W-1:0]   s_axi_bid,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ID_W-1:0]   s_axi_arid,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic [2:0]        s_axi_arsize,
  input  logic [1:0]        s_axi_arburst,
  input  logic              s_axi_arlock,
  input  logic [3:0]        s_axi_arcache,
  input  logic [2:0]        s_axi_arprot,
  input  logic [3:0]        s_axi_arregion,
  input  logic [3:0]        s_axi_arqos,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [ID_W-1:0]   s_axi_rid,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [ID_W-1:0]   m_axi_awid,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [7:0]        m_axi_awlen,
  output logic [2:0]        m_axi_awsize,
  output logic [1:0]        m_axi_awburst,
  output logic              m_axi_awlock,
  output logic [3:0]        m_axi_awcache,
  output logic [2:0]        m_axi_awprot,
  output logic [3:0]        m_axi_awregion,
  output logic [3:0]        m_axi_awqos,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic              m_axi_wlast,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [ID_W-1:0]   m_axi_bid,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ID_W-1:0]   m_axi_arid,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arlock,
  output logic [3:0]        m_axi_arcache,
  output logic [2:0]        m_axi_arprot,
  output logic [3:0]        m_axi_arregion,
  output logic [3:0]        m_axi_arqos,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [ID_W-1:0]   m_axi_rid,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned AX_W   = ID_W + ADDR_W + 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4;
  localparam int unsigned WD_W   = DATA_W + STRB_W + 1;
  localparam int unsigned B_W    = ID_W + 2;
  localparam int unsigned R_W    = ID_W + DATA_W + 2 + 1;

  if (!(DATA_W == 32 || DATA_W == 64 || DATA_W == 128 || DATA_W == 256)) begin : g_bad_data_w
    $fatal(1, "axi4_reg_slice: DATA_W must be 32, 64, 128 or 256");
  end
  if (ID_W < 1) begin : g_bad_id_w
    $fatal(1, "axi4_reg_slice: ID_W must be at least 1");
  end
  if (MODE_AW > 2 || MODE_W > 2 || MODE_B > 2 || MODE_AR > 2 || MODE_R > 2) begin : g_bad_mode
    $fatal(1, "axi4_reg_slice: MODE_x must be 0, 1 or 2");
  end

  // Flattened channel payloads, source side (_s) and sink side (_m).
  logic [AX_W-1:0] aw_s, aw_m, ar_s, ar_m;
  logic [WD_W-1:0] w_s, w_m;
  logic [B_W-1:0]  b_s, b_m;
  logic [R_W-1:0]  r_s, r_m;

  assign aw_s = {s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
                 s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awregion, s_axi_awqos};
  assign {m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
          m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awregion, m_axi_awqos} = aw_m;
  assign ar_s = {s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
                 s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arregion, s_axi_arqos};
  assign {m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
          m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arregion, m_axi_arqos} = ar_m;
  assign w_s = {s_axi_wdata, s_axi_wstrb, s_axi_wlast};
  assign {m_axi_wdata, m_axi_wstrb, m_axi_wlast} = w_m;
  assign b_s = {m_axi_bid, m_axi_bresp};
  assign {s_axi_bid, s_axi_bresp} = b_m;
  assign r_s = {m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast};
  assign {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast} = r_m;

  // Bypass channels are plain wires; registered ones get a channel stage.
  if (MODE_AW == 0) begin : g_aw_byp
    assign m_axi_awvalid = s_axi_awvalid;
    assign s_axi_awready = m_axi_awready;
    assign aw_m          = aw_s;
  end else begin : g_aw_reg
    axi4_reg_slice_chan #(.W(AX_W), .MODE(MODE_AW)) u_aw (
      .clk(aclk), .rst_n(aresetn),
      .valid_i(s_axi_awvalid), .ready_o(s_axi_awready), .data_i(aw_s),
      .valid_o(m_axi_awvalid), .ready_i(m_axi_awready), .data_o(aw_m));
  end

  if (MODE_W == 0) begin : g_w_byp
    assign m_axi_wvalid = s_axi_wvalid;
    assign s_axi_wready = m_axi_wready;
    assign w_m          = w_s;
  end else begin : g_w_reg
    axi4_reg_slice_chan #(.W(WD_W), .MODE(MODE_W)) u_w (
      .clk(aclk), .rst_n(aresetn),
      .valid_i(s_axi_wvalid), .ready_o(s_axi_wready), .data_i(w_s),
      .valid_o(m_axi_wvalid), .ready_i(m_axi_wready), .data_o(w_m));
  end

  if (MODE_B == 0) begin : g_b_byp
    assign s_axi_bvalid = m_axi_bvalid;
    assign m_axi_bready = s_axi_bready;
    assign b_m          = b_s;
  end else begin : g_b_reg
    axi4_reg_slice_chan #(.W(B_W), .MODE(MODE_B)) u_b (
      .clk(aclk), .rst_n(aresetn),
      .valid_i(m_axi_bvalid), .ready_o(m_axi_bready), .data_i(b_s),
      .valid_o(s_axi_bvalid), .ready_i(s_axi_bready), .data_o(b_m));
  end

  if (MODE_AR == 0) begin : g_ar_byp
    assign m_axi_arvalid = s_axi_arvalid;
    assign s_axi_arready = m_axi_arready;
    assign ar_m          = ar_s;
  end else begin : g_ar_reg
    axi4_reg_slice_chan #(.W(AX_W), .MODE(MODE_AR)) u_ar (
      .clk(aclk), .rst_n(aresetn),
      .valid_i(s_axi_arvalid), .ready_o(s_axi_arready), .data_i(ar_s),
      .valid_o(m_axi_arvalid), .ready_i(m_axi_arready), .data_o(ar_m));
  end

  if (MODE_R == 0) begin : g_r_byp
    assign s_axi_rvalid = m_axi_rvalid;
    assign m_axi_rready = s_axi_rready;
    assign r_m          = r_s;
  end else begin : g_r_reg
    axi4_reg_slice_chan #(.W(R_W), .MODE(MODE_R)) u_r (
      .clk(aclk), .rst_n(aresetn),
      .valid_i(m_axi_rvalid), .ready_o(m_axi_rready), .data_i(r_s),
      .valid_o(s_axi_rvalid), .ready_i(s_axi_rready), .data_o(r_m));
  end
endmodule

// File: tb/tb_axi4_reg_slice.sv
// Bench for axi4_reg_slice with AW/W/AR full, B bypass, R light.
module tb_axi4_reg_slice;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned AX_W   = ID_W + ADDR_W + 29;
  localparam int unsigned R_W    = ID_W + DATA_W + 3;

  logic aclk = 1'b0;
  logic aresetn;
  logic [ID_W-1:0] s_axi_awid, m_axi_awid, s_axi_arid, m_axi_arid;
  logic [ADDR_W-1:0] s_axi_awaddr, m_axi_awaddr, s_axi_araddr, m_axi_araddr;
  logic [7:0] s_axi_awlen, m_axi_awlen, s_axi_arlen, m_axi_arlen;
  logic [2:0] s_axi_awsize, m_axi_awsize, s_axi_arsize, m_axi_arsize;
  logic [1:0] s_axi_awburst, m_axi_awburst, s_axi_arburst, m_axi_arburst;
  logic s_axi_awlock, m_axi_awlock, s_axi_arlock, m_axi_arlock;
  logic [3:0] s_axi_awcache, m_axi_awcache, s_axi_arcache, m_axi_arcache;
  logic [2:0] s_axi_awprot, m_axi_awprot, s_axi_arprot, m_axi_arprot;
  logic [3:0] s_axi_awregion, m_axi_awregion, s_axi_arregion, m_axi_arregion;
  logic [3:0] s_axi_awqos, m_axi_awqos, s_axi_arqos, m_axi_arqos;
  logic s_axi_awvalid, s_axi_awready, m_axi_awvalid, m_axi_awready;
  logic s_axi_arvalid, s_axi_arready, m_axi_arvalid, m_axi_arready;
  logic [DATA_W-1:0] s_axi_wdata, m_axi_wdata, s_axi_rdata, m_axi_rdata;
  logic [STRB_W-1:0] s_axi_wstrb, m_axi_wstrb;
  logic s_axi_wlast, m_axi_wlast, s_axi_wvalid, s_axi_wready, m_axi_wvalid, m_axi_wready;
  logic [ID_W-1:0] s_axi_bid, m_axi_bid, s_axi_rid, m_axi_rid;
  logic [1:0] s_axi_bresp, m_axi_bresp, s_axi_rresp, m_axi_rresp;
  logic s_axi_bvalid, s_axi_bready, m_axi_bvalid, m_axi_bready;
  logic s_axi_rlast, m_axi_rlast, s_axi_rvalid, s_axi_rready, m_axi_rvalid, m_axi_rready;

  int total = 0;
  int bad   = 0;

  always #5 aclk = ~aclk;

  axi4_reg_slice #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
    .MODE_AW(1), .MODE_W(1), .MODE_B(0), .MODE_AR(1), .MODE_R(2)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
    .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awregion(s_axi_awregion),
    .s_axi_awqos(s_axi_awqos), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
    .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arregion(s_axi_arregion),
    .s_axi_arqos(s_axi_arqos), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awregion(m_axi_awregion),
    .m_axi_awqos(m_axi_awqos), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arregion(m_axi_arregion),
    .m_axi_arqos(m_axi_arqos), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  // Whole AW beat as one vector, source and sink side.
  function automatic logic [AX_W-1:0] aw_src();
    return {s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
            s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awregion, s_axi_awqos};
  endfunction
  function automatic logic [AX_W-1:0] aw_snk();
    return {m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
            m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awregion, m_axi_awqos};
  endfunction

  task automatic rand_aw();
    s_axi_awid = ID_W'($urandom);        s_axi_awaddr = $urandom;
    s_axi_awlen = 8'($urandom);          s_axi_awsize = 3'($urandom);
    s_axi_awburst = 2'($urandom);        s_axi_awlock = 1'($urandom);
    s_axi_awcache = 4'($urandom);        s_axi_awprot = 3'($urandom);
    s_axi_awregion = 4'($urandom);       s_axi_awqos = 4'($urandom);
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0; s_axi_bready = 0; s_axi_rready = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0; m_axi_bvalid = 0; m_axi_rvalid = 0;
    rand_aw();
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0; s_axi_arburst = '0;
    s_axi_arlock = 0; s_axi_arcache = '0; s_axi_arprot = '0; s_axi_arregion = '0; s_axi_arqos = '0;
    m_axi_bid = '0; m_axi_bresp = '0;
    m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 0;
    repeat (5) @(negedge aclk);
    #1;
    total++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready, m_axi_rready, m_axi_bready} !== 5'b00000) begin
      bad++;
      $display("FAIL reset_readies got=%b exp=00000",
               {s_axi_awready, s_axi_wready, s_axi_arready, m_axi_rready, m_axi_bready});
    end
    total++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, s_axi_rvalid, s_axi_bvalid} !== 5'b00000) begin
      bad++;
      $display("FAIL reset_valids got=%b exp=00000",
               {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, s_axi_rvalid, s_axi_bvalid});
    end
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    total++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready, m_axi_rready} !== 4'b0000) begin
      bad++;
      $display("FAIL release_no_edge_readies got=%b exp=0000",
               {s_axi_awready, s_axi_wready, s_axi_arready, m_axi_rready});
    end
    @(negedge aclk);
    #1;
    total++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready, m_axi_rready} !== 4'b1111) begin
      bad++;
      $display("FAIL post_release_readies got=%b exp=1111",
               {s_axi_awready, s_axi_wready, s_axi_arready, m_axi_rready});
    end
    s_axi_bready = 1'b1;
    #1;
    total++;
    if (m_axi_bready !== 1'b1) begin
      bad++;
      $display("FAIL post_release_bready got=%b exp=1", m_axi_bready);
    end
    s_axi_bready = 1'b0;
  endtask

  // 16 W beats with the sink always ready: 1-cycle latency, one beat per cycle.
  task automatic test_back_to_back();
    logic [DATA_W+STRB_W:0] q[$];
    logic [DATA_W+STRB_W:0] exp;
    int first_valid = -1;
    int last_valid  = -1;
    int nvalid      = 0;
    int naccept     = 0;
    m_axi_wready = 1'b1;
    for (int k = 0; k < 19; k++) begin
      @(negedge aclk);
      if (k < 16) begin
        s_axi_wvalid = 1'b1;
        s_axi_wdata  = DATA_W'(k);
        s_axi_wstrb  = STRB_W'($urandom);
        s_axi_wlast  = (k == 15);
      end else begin
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
      end
      #1;
      if (m_axi_wvalid) begin
        if (first_valid < 0) first_valid = k;
        last_valid = k;
        nvalid++;
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL b2b_unexpected_beat cycle=%0d data=%h", k, m_axi_wdata);
        end else begin
          exp = q.pop_front();
          if ({m_axi_wdata, m_axi_wstrb, m_axi_wlast} !== exp) begin
            bad++;
            $display("FAIL b2b_beat cycle=%0d got=%h exp=%h", k,
                     {m_axi_wdata, m_axi_wstrb, m_axi_wlast}, exp);
          end
        end
      end
      if (s_axi_wvalid && s_axi_wready) begin
        q.push_back({s_axi_wdata, s_axi_wstrb, s_axi_wlast});
        naccept++;
      end
    end
    total++;
    if (first_valid !== 1) begin
      bad++;
      $display("FAIL b2b_latency got=%0d exp=1", first_valid);
    end
    total++;
    if (nvalid !== 16 || last_valid !== 16 || naccept !== 16) begin
      bad++;
      $display("FAIL b2b_throughput got=%0d/%0d/%0d exp=16/16/16", nvalid, last_valid, naccept);
    end
  endtask

  // Randomized AW traffic against an occupancy/FIFO model of a 2-entry buffer.
  task automatic test_random_aw();
    logic [AX_W-1:0] q[$];
    logic [AX_W-1:0] hold_val;
    logic hold_pend = 1'b0;
    logic s_pend    = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge aclk);
      if (!s_pend) begin
        s_axi_awvalid = ($urandom_range(0, 99) < 70);
        rand_aw();
      end
      m_axi_awready = ($urandom_range(0, 99) < 55);
      #1;
      total++;
      if (s_axi_awready !== (q.size() < 2)) begin
        bad++;
        $display("FAIL aw_ready cycle=%0d got=%b exp=%b", k, s_axi_awready, q.size() < 2);
      end
      total++;
      if (m_axi_awvalid !== (q.size() != 0)) begin
        bad++;
        $display("FAIL aw_valid cycle=%0d got=%b exp=%b", k, m_axi_awvalid, q.size() != 0);
      end
      if (hold_pend) begin
        total++;
        if (m_axi_awvalid !== 1'b1 || aw_snk() !== hold_val) begin
          bad++;
          $display("FAIL aw_stall_stable cycle=%0d got=%b/%h exp=1/%h", k, m_axi_awvalid, aw_snk(), hold_val);
        end
      end
      if (m_axi_awvalid && m_axi_awready && q.size() != 0) begin
        total++;
        if (aw_snk() !== q[0]) begin
          bad++;
          $display("FAIL aw_order cycle=%0d got=%h exp=%h", k, aw_snk(), q[0]);
        end
        void'(q.pop_front());
      end
      hold_pend = m_axi_awvalid && !m_axi_awready;
      hold_val  = aw_snk();
      if (s_axi_awvalid && s_axi_awready) begin
        q.push_back(aw_src());
        s_pend = 1'b0;
      end else begin
        s_pend = s_axi_awvalid;
      end
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge aclk);
      s_axi_awvalid = 1'b0;
      m_axi_awready = 1'b1;
      #1;
      if (m_axi_awvalid && q.size() != 0) begin
        total++;
        if (aw_snk() !== q[0]) begin
          bad++;
          $display("FAIL aw_drain cycle=%0d got=%h exp=%h", k, aw_snk(), q[0]);
        end
        void'(q.pop_front());
      end
    end
    total++;
    if (q.size() != 0 || m_axi_awvalid !== 1'b0) begin
      bad++;
      $display("FAIL aw_drained left=%0d valid=%b exp=0/0", q.size(), m_axi_awvalid);
    end
  endtask

  // Three ARs into a stalled sink: two fit, the third waits, then all leave in order.
  task automatic test_backpressure();
    logic [ADDR_W-1:0] addrs[3];
    logic [ADDR_W-1:0] seen[$];
    int sent = 0;
    addrs[0] = 32'h1000; addrs[1] = 32'h1004; addrs[2] = 32'h1008;
    m_axi_arready = 1'b0;
    s_axi_arid = 4'd3;
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      s_axi_arvalid = 1'b1;
      s_axi_araddr  = addrs[k];
      #1;
      total++;
      if (s_axi_arready !== (k < 2)) begin
        bad++;
        $display("FAIL ar_ready_beat%0d got=%b exp=%b", k, s_axi_arready, k < 2);
      end
    end
    repeat (3) begin
      @(negedge aclk);
      #1;
      total++;
      if ({m_axi_arvalid, m_axi_arid, m_axi_araddr, s_axi_arready} !== {1'b1, 4'd3, 32'h1000, 1'b0}) begin
        bad++;
        $display("FAIL ar_stall got=%b/%h/%h/%b exp=1/3/1000/0",
                 m_axi_arvalid, m_axi_arid, m_axi_araddr, s_axi_arready);
      end
    end
    sent = 2;
    for (int k = 0; k < 8; k++) begin
      @(negedge aclk);
      m_axi_arready = 1'b1;
      if (sent == 3) s_axi_arvalid = 1'b0;
      #1;
      if (m_axi_arvalid && m_axi_arready) seen.push_back(m_axi_araddr);
      if (s_axi_arvalid && s_axi_arready) sent = 3;
    end
    total++;
    if (seen.size() != 3) begin
      bad++;
      $display("FAIL ar_exit_count got=%0d exp=3", seen.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (seen[i] !== addrs[i]) begin
          bad++;
          $display("FAIL ar_exit_order idx=%0d got=%h exp=%h", i, seen[i], addrs[i]);
        end
      end
    end
    m_axi_arready = 1'b0;
  endtask

  // Light R: source valid for 10 cycles yields 5 beats, one every 2 cycles; then random traffic.
  task automatic test_light_r();
    logic [R_W-1:0] q[$];
    int n_acc = 0;
    int got_data[$];
    int got_cyc[$];
    logic s_pend = 1'b0;
    s_axi_rready = 1'b1;
    m_axi_rid = 4'd9; m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(negedge aclk);
      m_axi_rvalid = (k < 10);
      m_axi_rdata  = DATA_W'(n_acc);
      #1;
      if (s_axi_rvalid && s_axi_rready) begin
        got_data.push_back(int'(s_axi_rdata));
        got_cyc.push_back(k);
      end
      if (m_axi_rvalid && m_axi_rready) n_acc++;
    end
    total++;
    if (n_acc != 5 || got_data.size() != 5) begin
      bad++;
      $display("FAIL r_light_count got=%0d/%0d exp=5/5", n_acc, got_data.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (got_data[i] != i || (i > 0 && got_cyc[i] - got_cyc[i-1] != 2)) begin
          bad++;
          $display("FAIL r_light_beat idx=%0d got=%0d@%0d exp=%0d", i, got_data[i], got_cyc[i], i);
        end
      end
    end
    for (int k = 0; k < 120; k++) begin
      @(negedge aclk);
      if (!s_pend) begin
        m_axi_rvalid = ($urandom_range(0, 99) < 70);
        m_axi_rid = ID_W'($urandom); m_axi_rdata = $urandom;
        m_axi_rresp = 2'($urandom);  m_axi_rlast = 1'($urandom);
      end
      s_axi_rready = ($urandom_range(0, 99) < 60);
      #1;
      total++;
      if ({m_axi_rready, s_axi_rvalid} !== {q.size() == 0, q.size() == 1}) begin
        bad++;
        $display("FAIL r_light_flags cycle=%0d got=%b%b exp=%b%b", k, m_axi_rready, s_axi_rvalid,
                 q.size() == 0, q.size() == 1);
      end
      if (s_axi_rvalid && s_axi_rready && q.size() != 0) begin
        total++;
        if ({s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast} !== q[0]) begin
          bad++;
          $display("FAIL r_light_data cycle=%0d got=%h exp=%h", k,
                   {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast}, q[0]);
        end
        void'(q.pop_front());
      end
      if (m_axi_rvalid && m_axi_rready) begin
        q.push_back({m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast});
        s_pend = 1'b0;
      end else begin
        s_pend = m_axi_rvalid;
      end
    end
    @(negedge aclk);
    m_axi_rvalid = 1'b0;
    s_axi_rready = 1'b1;
    repeat (2) @(negedge aclk);
  endtask

  // Bypass B: outputs follow inputs within the same cycle, both directions.
  task automatic test_bypass_b();
    for (int k = 0; k < 10; k++) begin
      @(negedge aclk);
      if (k == 0) begin
        m_axi_bvalid = 1'b1; m_axi_bresp = 2'b10; m_axi_bid = 4'd5; s_axi_bready = 1'b0;
      end else begin
        m_axi_bvalid = 1'($urandom); m_axi_bresp = 2'($urandom);
        m_axi_bid = ID_W'($urandom); s_axi_bready = 1'($urandom);
      end
      #1;
      total++;
      if ({s_axi_bvalid, s_axi_bresp, s_axi_bid, m_axi_bready} !==
          {m_axi_bvalid, m_axi_bresp, m_axi_bid, s_axi_bready}) begin
        bad++;
        $display("FAIL b_bypass cycle=%0d got=%b/%b/%h/%b exp=%b/%b/%h/%b", k,
                 s_axi_bvalid, s_axi_bresp, s_axi_bid, m_axi_bready,
                 m_axi_bvalid, m_axi_bresp, m_axi_bid, s_axi_bready);
      end
    end
    @(negedge aclk);
    m_axi_bvalid = 1'b0;
    s_axi_bready = 1'b0;
  endtask

  // Fill AW to two entries, pulse reset, and confirm nothing comes out until a new beat.
  task automatic test_reset_mid();
    logic [AX_W-1:0] fresh;
    m_axi_awready = 1'b0;
    repeat (2) begin
      @(negedge aclk);
      s_axi_awvalid = 1'b1;
      rand_aw();
    end
    @(negedge aclk);
    s_axi_awvalid = 1'b0;
    #1;
    total++;
    if ({s_axi_awready, m_axi_awvalid} !== 2'b01) begin
      bad++;
      $display("FAIL aw_full_before_reset got=%b%b exp=01", s_axi_awready, m_axi_awvalid);
    end
    #1 aresetn = 1'b0;
    #1;
    total++;
    if (m_axi_awvalid !== 1'b0) begin
      bad++;
      $display("FAIL aw_valid_async_drop got=%b exp=0", m_axi_awvalid);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    m_axi_awready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++;
      if (m_axi_awvalid !== 1'b0) begin
        bad++;
        $display("FAIL aw_valid_after_reset cycle=%0d got=%b exp=0", k, m_axi_awvalid);
      end
      @(negedge aclk);
    end
    s_axi_awvalid = 1'b1;
    rand_aw();
    fresh = aw_src();
    #1;
    total++;
    if (s_axi_awready !== 1'b1) begin
      bad++;
      $display("FAIL aw_ready_after_reset got=%b exp=1", s_axi_awready);
    end
    @(negedge aclk);
    s_axi_awvalid = 1'b0;
    #1;
    total++;
    if (m_axi_awvalid !== 1'b1 || aw_snk() !== fresh) begin
      bad++;
      $display("FAIL aw_new_beat got=%b/%h exp=1/%h", m_axi_awvalid, aw_snk(), fresh);
    end
    @(negedge aclk);
    #1;
    total++;
    if (m_axi_awvalid !== 1'b0) begin
      bad++;
      $display("FAIL aw_new_beat_drained got=%b exp=0", m_axi_awvalid);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_random_aw();
    test_backpressure();
    test_light_r();
    test_bypass_b();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
